// File: rtl/ysyx_22040365_ex_ctrl.sv
// EX-stage sequencer: accepts one decoded op, feeds the EX datapath for the op's
// latency, then holds the captured result until writeback takes it.
module ysyx_22040365_ex_ctrl #(
  parameter int XLEN     = 64,
  parameter int LONG_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [1:0]      in_op_type,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [1:0]      ex_op_type,
  input  logic [XLEN-1:0] ex_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LONG = 2'b11;

  // Counter preload: the op completes on the cycle the counter reads zero.
  localparam logic [3:0] LONG_CNT = 4'(LONG_LAT - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] ex_op1_q, ex_op1_d;
  logic [XLEN-1:0] ex_op2_q, ex_op2_d;
  logic [1:0]      ex_op_type_q, ex_op_type_d;
  logic [4:0]      rd_q, rd_d;
  logic            wen_q, wen_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_wen_q, out_wen_d;
  logic            accept;

  assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_op1_d     = ex_op1_q;
    ex_op2_d     = ex_op2_q;
    ex_op_type_d = ex_op_type_q;
    rd_d         = rd_q;
    wen_d        = wen_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wen_d    = out_wen_q;

    if (flush) begin
      // A held result is dropped here even if WB raises out_ready this cycle.
      state_d     = S_IDLE;
      cnt_d       = 4'd0;
      out_valid_d = 1'b0;
      out_wen_d   = 1'b0;
    end else begin
      case (state_q)
        S_EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            out_result_d = ex_result;
            out_rd_d     = rd_q;
            out_wen_d    = wen_q && (ex_op_type_q != OP_NOP);
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the DONE->IDLE step so a new op can issue on the retire edge.
      if (accept) begin
        ex_op1_d     = in_op1;
        ex_op2_d     = in_op2;
        ex_op_type_d = in_op_type;
        rd_d         = in_rd;
        wen_d        = in_wen;
        cnt_d        = (in_op_type == OP_LONG) ? LONG_CNT : 4'd0;
        state_d      = S_EXEC;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      ex_op1_q     <= '0;
      ex_op2_q     <= '0;
      ex_op_type_q <= 2'b00;
      rd_q         <= 5'd0;
      wen_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= 5'd0;
      out_wen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_op1_q     <= ex_op1_d;
      ex_op2_q     <= ex_op2_d;
      ex_op_type_q <= ex_op_type_d;
      rd_q         <= rd_d;
      wen_q        <= wen_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wen_q    <= out_wen_d;
    end
  end

  assign ex_op1     = ex_op1_q;
  assign ex_op2     = ex_op2_q;
  assign ex_op_type = ex_op_type_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_wen    = out_wen_q;
  assign busy       = (state_q == S_EXEC);

endmodule

// File: tb/tb_ysyx_22040365_ex_ctrl.sv
// Bench for the EX sequencer: directed ops feed a scoreboard queue; a monitor
// pops and compares every result WB actually takes.
module tb_ysyx_22040365_ex_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_wen;
  logic [63:0] in_op1, in_op2, ex_op1, ex_op2, ex_result, out_result;
  logic [1:0]  in_op_type, ex_op_type;
  logic [4:0]  in_rd, out_rd;
  logic        out_valid, out_ready, out_wen, busy;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t        sb[$];
  int          deliver_cyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] dp_noise = '0;

  ysyx_22040365_ex_ctrl #(.XLEN(64), .LONG_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_op_type(in_op_type),
    .in_rd(in_rd), .in_wen(in_wen),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op_type(ex_op_type),
    .ex_result(ex_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Datapath stand-in: LONG computes op1-op2, NOP passes op1 through.
  always_comb begin
    case (ex_op_type)
      2'b01:   ex_result = ex_op1 + ex_op2;
      2'b10:   ex_result = '0;
      2'b11:   ex_result = ex_op1 - ex_op2;
      default: ex_result = ex_op1;
    endcase
    ex_result = ex_result ^ dp_noise;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake at the coming edge is a delivery unless flush kills it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !flush) begin
        deliver_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_result", out_result, 64'hx);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("rd", 64'(out_rd), 64'(e.rd));
          check("wen", 64'(out_wen), 64'(e.wen));
        end
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] t,
                       input logic [4:0] rd, input logic wen,
                       input logic [63:0] er, input logic ew, input bit push);
    int n;
    in_valid = 1'b1; in_op1 = a; in_op2 = b; in_op_type = t; in_rd = rd; in_wen = wen;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    check("issue_accept", 64'(in_ready), 64'd1);
    if (push) sb.push_back('{res: er, rd: rd, wen: ew});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(sb.size() == 0 && !out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op1 = '0; in_op2 = '0; in_op_type = 2'b00; in_rd = '0; in_wen = 1'b0;

    // 1. Reset values, then a single ADD.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ex_op1", ex_op1, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b1;
    #1;
    check("rst_in_ready_flush", 64'(in_ready), 64'd0);
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(64'd5, 64'd7, 2'b01, 5'd3, 1'b1, 64'd12, 1'b1, 1'b1);
    check("add_latency_pre", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("add_latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    check("add_back_idle", 64'(out_valid), 64'd0);
    check("add_idle_ready", 64'(in_ready), 64'd1);
    drain();

    // 2. Wraparound ADD, ZERO, NOP write-enable suppression.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b01, 5'd7, 1'b1, 64'd0, 1'b1, 1'b1);
    issue(64'd9, 64'd9, 2'b10, 5'd8, 1'b1, 64'd0, 1'b1, 1'b1);
    issue(64'h55, 64'd0, 2'b00, 5'd9, 1'b1, 64'h55, 1'b0, 1'b1);
    drain();

    // 3. LONG op: four busy cycles, then hold with WB stalled.
    out_ready = 1'b0;
    issue(64'h10, 64'h3, 2'b11, 5'd10, 1'b1, 64'hD, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("long_busy", 64'(busy), 64'd1);
      check("long_in_ready", 64'(in_ready), 64'd0);
      check("long_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    check("long_valid", 64'(out_valid), 64'd1);
    check("long_busy_done", 64'(busy), 64'd0);
    dp_noise = 64'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", out_result, 64'hD);
      check("hold_rd", 64'(out_rd), 64'd10);
      check("hold_wen", 64'(out_wen), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    dp_noise = '0;
    out_ready = 1'b1;
    drain();

    // 4. Back-to-back stream of ADDs.
    deliver_cyc.delete();
    issue(64'd1, 64'd2, 2'b01, 5'd11, 1'b1, 64'd3, 1'b1, 1'b1);
    issue(64'd10, 64'd20, 2'b01, 5'd12, 1'b1, 64'd30, 1'b1, 1'b1);
    issue(64'h100, 64'h200, 2'b01, 5'd13, 1'b0, 64'h300, 1'b0, 1'b1);
    issue(64'hF000_0000_0000_0000, 64'h1000_0000_0000_0001, 2'b01, 5'd14, 1'b1, 64'd1, 1'b1, 1'b1);
    drain();
    check("stream_count", 64'(deliver_cyc.size()), 64'd4);
    if (deliver_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("stream_spacing", 64'(deliver_cyc[i] - deliver_cyc[i-1]), 64'd2);
    end

    // 5a. Flush during LONG EXEC with a competing in_valid.
    issue(64'h30, 64'h10, 2'b11, 5'd5, 1'b1, 64'h20, 1'b1, 1'b0);
    in_valid = 1'b1; in_op1 = 64'd1; in_op2 = 64'd2; in_op_type = 2'b01; in_rd = 5'd6;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_exec_busy", 64'(busy), 64'd0);
    check("flush_exec_valid", 64'(out_valid), 64'd0);
    check("flush_no_accept_type", 64'(ex_op_type), 64'd3);
    check("flush_no_accept_op1", ex_op1, 64'h30);
    repeat (6) @(posedge clk);
    #1;
    check("flush_exec_quiet", 64'(out_valid), 64'd0);

    // 5b. Flush while a result is held and WB is ready.
    out_ready = 1'b0;
    issue(64'd2, 64'd2, 2'b01, 5'd6, 1'b1, 64'd4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("flush_done_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done_valid_drop", 64'(out_valid), 64'd0);
    check("flush_done_wen", 64'(out_wen), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd0);

    // 6. Asynchronous reset in the middle of a LONG op.
    out_ready = 1'b0;
    issue(64'h20, 64'h1, 2'b11, 5'd4, 1'b1, 64'h1F, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ex_op1", ex_op1, 64'd0);
    check("arst_ex_op_type", 64'(ex_op_type), 64'd0);
    check("arst_out_result", out_result, 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(64'd1, 64'd1, 2'b01, 5'd1, 1'b1, 64'd2, 1'b1, 1'b1);
    drain();

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
